// File: rtl/uart_pkg.sv
// Shared UART receive-path types: parity modes, parity-unit FSM states and
// the expected-parity rule.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_typ_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ACC      = 2'b01,
    WAIT_PAR = 2'b10
  } par_state_e;

  // acc is the XOR of all data bits received so far.
  function automatic logic expected_parity(input par_typ_e typ, input logic acc);
    case (typ)
      PAR_EVEN:  return acc;
      PAR_ODD:   return ~acc;
      PAR_MARK:  return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; a clear coinciding with an increment yields 1 so
// the newest event is never lost.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr && inc)             cnt_d = WIDTH'(1);
    else if (clr)               cnt_d = '0;
    else if (inc && ~&cnt_q)    cnt_d = cnt_q + WIDTH'(1);
  end

  // NOTE: state registers use <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/uart_rx_par_unit.sv
// Serial parity accumulator/checker for the UART RX path: per-frame result
// pulses, sticky error flag and saturating error count, all registered.
module uart_rx_par_unit
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 data_bit_valid,
  input  logic                 par_bit_valid,
  input  logic                 sampled_bit,
  input  logic                 par_en,
  input  logic [1:0]           par_typ,
  input  logic                 err_clr,
  output logic                 par_done,
  output logic                 par_err,
  output logic                 seq_err,
  output logic                 par_err_sticky,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  localparam int                   BIT_CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_WIDTH - 1);

  par_state_e           state_q, state_d;
  logic                 acc_q, acc_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 par_en_q, par_en_d;
  par_typ_e             par_typ_q, par_typ_d;
  logic                 done_q, done_d;
  logic                 perr_q, perr_d;
  logic                 serr_q, serr_d;
  logic                 sticky_q, sticky_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d   = state_q;
    acc_d     = acc_q;
    bit_cnt_d = bit_cnt_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    done_d    = 1'b0;
    perr_d    = 1'b0;
    serr_d    = 1'b0;

    if (frame_start) begin
      // A restart silently drops whatever frame was in flight.
      state_d   = ACC;
      acc_d     = 1'b0;
      bit_cnt_d = '0;
      par_en_d  = par_en;
      par_typ_d = par_typ_e'(par_typ);
    end else if (data_bit_valid && par_bit_valid) begin
      serr_d  = 1'b1;
      state_d = IDLE;
    end else begin
      case (state_q)
        ACC: begin
          if (par_bit_valid) begin
            serr_d  = 1'b1;
            state_d = IDLE;
          end else if (data_bit_valid) begin
            acc_d     = acc_q ^ sampled_bit;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_q == LAST_BIT) begin
              if (par_en_q) begin
                state_d = WAIT_PAR;
              end else begin
                done_d  = 1'b1;
                state_d = IDLE;
              end
            end
          end
        end
        WAIT_PAR: begin
          if (data_bit_valid) begin
            serr_d  = 1'b1;
            state_d = IDLE;
          end else if (par_bit_valid) begin
            done_d  = 1'b1;
            perr_d  = sampled_bit != expected_parity(par_typ_q, acc_q);
            state_d = IDLE;
          end
        end
        default: begin
          if (data_bit_valid || par_bit_valid) serr_d = 1'b1;
          state_d = IDLE;
        end
      endcase
    end
  end

  // A new error outranks a coincident clear.
  assign sticky_d = perr_d ? 1'b1 : (err_clr ? 1'b0 : sticky_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      acc_q     <= 1'b0;
      bit_cnt_q <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      done_q    <= 1'b0;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      bit_cnt_q <= bit_cnt_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      done_q    <= done_d;
      perr_q    <= perr_d;
      serr_q    <= serr_d;
      sticky_q  <= sticky_d;
    end
  end

  // Fed from the next-state error so the count lands with the par_err pulse.
  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (perr_d),
    .clr (err_clr),
    .cnt (err_cnt)
  );

  assign par_done       = done_q;
  assign par_err        = perr_q;
  assign seq_err        = serr_q;
  assign par_err_sticky = sticky_q;

endmodule

// File: doc/uart_rx_par_unit.md
# uart_rx_par_unit

Parametrised, sequential parity unit for the UART receive path. It accumulates parity serially as the bit sampler delivers data bits, then checks the received parity bit against one of four parity types. It reports a registered per-frame result, a sticky error flag and a saturating error counter. It sits between the RX bit sampler and the RX FSM, and is the successor of the combinational `par_chk`.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: data bits per frame, legal range 5..9.
- `CNT_WIDTH`, default 8: width of the error counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `frame_start`  in  1  start-bit accepted; opens a new frame.
- `data_bit_valid`  in  1  `sampled_bit` carries a data bit this cycle.
- `par_bit_valid`  in  1  `sampled_bit` carries the parity bit this cycle.
- `sampled_bit`  in  1  sampled line value.
- `par_en`  in  1  parity enabled; latched at `frame_start`.
- `par_typ`  in  2  parity type, latched at `frame_start`: 00 even, 01 odd, 10 mark, 11 space.
- `err_clr`  in  1  clears the sticky flag and the counter.
- `par_done`  out  1  one-cycle pulse: frame check complete.
- `par_err`  out  1  one-cycle pulse, coincident with `par_done`: parity mismatch.
- `seq_err`  out  1  one-cycle pulse: strobe protocol violation.
- `par_err_sticky`  out  1  set by `par_err`, cleared only by `err_clr` or reset.
- `err_cnt`  out  CNT_WIDTH  saturating count of `par_err` pulses.

## Operation
- FSM states:
  - IDLE: the reset state.
  - ACC: collecting data bits.
  - WAIT_PAR: waiting for the parity bit.
- `frame_start`:
  - Has priority over all other inputs in any state.
  - Clears the accumulator and the bit counter, latches `par_en`/`par_typ`, and enters ACC.
  - A mid-frame restart silently abandons the old frame with no `seq_err`.
- ACC, on `data_bit_valid`:
  - acc ^= `sampled_bit`, and the bit counter increments.
  - On the DATA_WIDTH-th bit: go to WAIT_PAR if `par_en` is latched; otherwise pulse `par_done` with `par_err`=0 and return to IDLE.
- WAIT_PAR, on `par_bit_valid`, the expected parity bit is:
  - even: acc
  - odd: ~acc
  - mark: 1
  - space: 0
- In WAIT_PAR, a mismatch pulses `par_err`. `par_done` is pulsed in either case, and the FSM returns to IDLE.
- Sequence errors pulse `seq_err`, leave `par_done` low, and force IDLE:
  - `par_bit_valid` in IDLE or ACC.
  - `data_bit_valid` in IDLE or WAIT_PAR.
  - `data_bit_valid` and `par_bit_valid` asserted in the same cycle, in any state.
- `err_cnt`:
  - Increments on each `par_err`.
  - Holds at all-ones when saturated.
- `err_clr`:
  - Zeroes `err_cnt` and `par_err_sticky`.
  - If it coincides with a `par_err`, the new event wins: `err_cnt`=1 and sticky=1.
- Bit counter width: clog2(DATA_WIDTH+1). The counter never wraps, because the FSM leaves ACC at DATA_WIDTH.

## Timing
- All outputs are registered.
- `par_done`, `par_err` and `seq_err` assert in the cycle after the triggering strobe edge, for exactly one cycle.
- Latency:
  - With parity enabled: 1 cycle from the `par_bit_valid` edge to `par_done`.
  - With parity disabled: 1 cycle from the last `data_bit_valid` edge to `par_done`.
- `err_cnt` and `par_err_sticky` update in the same cycle as the `par_err` pulse.
- Reset values: all outputs 0, FSM in IDLE, accumulator 0, bit counter 0, latched mode = even with `par_en`=0.
- Reset asserted mid-frame aborts the frame immediately. No pulse is produced after release until a new `frame_start`.
- Back-to-back frames: `frame_start` is allowed in the same cycle that `par_done` is being output.

## Structure
- Shared package `uart_pkg` holds:
  - `par_typ_e` (PAR_EVEN=2'b00, PAR_ODD=2'b01, PAR_MARK=2'b10, PAR_SPACE=2'b11).
  - `par_state_e` (IDLE, ACC, WAIT_PAR).
- One sub-module, `sat_counter`: parameter WIDTH, with inc, clr and `cnt` ports; clr and inc together yield 1. It implements `err_cnt` and is reusable for framing-error counting.
- The FSM, accumulator and check logic live in `uart_rx_par_unit`.

## Test plan
- Even parity, DATA_WIDTH=8: data 8'hF0 LSB-first, then parity bit 0 → `par_done`=1, `par_err`=0. Repeat with parity bit 1 → `par_err`=1, sticky=1, `err_cnt`=1.
- Odd/mark/space with data 8'hF0:
  - Odd: parity 1 passes, 0 fails.
  - Mark: parity 0 → `par_err`.
  - Space: parity 1 → `par_err`.
  - `par_typ` changed mid-frame has no effect.
- `par_en`=0: 8 data bits → `par_done` one cycle after the 8th bit, no parity bit consumed. A following `par_bit_valid` → `seq_err`=1.
- CNT_WIDTH=2: 5 failing frames → `err_cnt` holds at 3. Then `err_clr` coincident with a 6th failure → `err_cnt`=1, sticky=1.
- Protocol violations:
  - `par_bit_valid` after 3 data bits → `seq_err`, back to IDLE.
  - Simultaneous valids → `seq_err`.
  - `frame_start` after 4 bits → restart, with a clean result on the next full frame.
- Reset: `rst` low after 5 data bits → all outputs 0, IDLE. No pulse after release. The next full frame checks correctly.
